spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_master_ctrl.sv | 145 ++++++++++++++
 tb/tb_spi_master_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master (CPOL=0, CPHA=1) issuing one 16-bit frame {rw, addr[6:0], data[7:0]} MSB first.
// A read returns the byte shifted in on the last eight falling sclk edges.
module spi_master_ctrl #(
  parameter int unsigned HALF_PERIOD = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso,
  output logic       cs
);

  typedef enum logic [1:0] {StIdle, StLead, StShift, StTrail} state_e;

  localparam logic [7:0] HpLast = 8'(HALF_PERIOD - 1);

  state_e      state_q, state_d;
  logic [7:0]  hp_cnt_q, hp_cnt_d;
  logic [4:0]  edge_cnt_q, edge_cnt_d;
  logic [15:0] frame_q, frame_d;
  logic        rw_q, rw_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic        cs_q, cs_d;
  logic        half_end;

  assign half_end = (hp_cnt_q == HpLast);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      hp_cnt_q   <= 8'h00;
      edge_cnt_q <= 5'd0;
      frame_q    <= 16'h0000;
      rw_q       <= 1'b0;
      rx_q       <= 8'h00;
      rdata_q    <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      hp_cnt_q   <= hp_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      frame_q    <= frame_d;
      rw_q       <= rw_d;
      rx_q       <= rx_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_q       <= cs_d;
    end
  end

  // edge_cnt_q holds (toggles issued - 1); SHIFT ends one half-period after toggle 32.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLead;
      StLead:  if (half_end) state_d = StShift;
      StShift: if (half_end && edge_cnt_q == 5'd31) state_d = StTrail;
      StTrail: if (half_end) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    hp_cnt_d   = half_end ? 8'h00 : hp_cnt_q + 8'd1;
    edge_cnt_d = edge_cnt_q;
    frame_d    = frame_q;
    rw_d       = rw_q;
    rx_d       = rx_q;
    rdata_d    = rdata_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_d       = cs_q;
    case (state_q)
      StIdle: begin
        hp_cnt_d = 8'h00;
        if (start) begin
          frame_d = {rw, addr, (rw ? 8'h00 : wdata)};
          rw_d    = rw;
          cs_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StLead: begin
        if (half_end) begin
          edge_cnt_d = 5'd0;
          sclk_d     = 1'b1;
          mosi_d     = frame_q[15];
          frame_d    = {frame_q[14:0], 1'b0};
        end
      end
      StShift: begin
        if (half_end && edge_cnt_q != 5'd31) begin
          edge_cnt_d = edge_cnt_q + 5'd1;
          sclk_d     = ~sclk_q;
          if (!sclk_q) begin
            mosi_d  = frame_q[15];
            frame_d = {frame_q[14:0], 1'b0};
          end else begin
            rx_d = {rx_q[6:0], miso};
          end
        end
      end
      StTrail: begin
        if (half_end) begin
          cs_d   = 1'b1;
          busy_d = 1'b0;
          done_d = 1'b1;
          mosi_d = 1'b0;
          if (rw_q) rdata_d = rx_q;
        end
      end
      default: ;
    endcase
  end

  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign sclk  = sclk_q;
  assign mosi  = mosi_q;
  assign cs    = cs_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: two instances (HALF_PERIOD 4 and 2) share stimulus and are
// compared every cycle against a frame-offset model, plus directed literal checks.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] addr = 7'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata_w [2];
  logic       busy_w [2], done_w [2], sclk_w [2], mosi_w [2], cs_w [2];
  logic       miso_w [2] = '{1'b0, 1'b0};

  int checks = 0;
  int failures = 0;
  bit run = 1'b0;

  spi_master_ctrl #(.HALF_PERIOD(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[0]), .busy(busy_w[0]), .done(done_w[0]), .sclk(sclk_w[0]),
    .mosi(mosi_w[0]), .miso(miso_w[0]), .cs(cs_w[0])
  );

  spi_master_ctrl #(.HALF_PERIOD(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata_w[1]), .busy(busy_w[1]), .done(done_w[1]), .sclk(sclk_w[1]),
    .mosi(mosi_w[1]), .miso(miso_w[1]), .cs(cs_w[1])
  );

  function automatic int hp_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures < 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model: k = cycles since start was accepted (0 = idle), frame length 34*hp, done at 34*hp+1.
  int         mk [2] = '{0, 0};
  logic [15:0] mfr [2];
  logic       mrw [2];
  logic [7:0] mrx [2], mjunk [2], nrx [2];
  logic [7:0] mexp [2] = '{8'h00, 8'h00};
  logic [7:0] njunk = 8'h00;

  function automatic void exp_out(input int k, input int hp, input logic [15:0] fr,
                                  output logic [4:0] o);
    logic c, s, m, b, d;
    int h;
    c = 1'b1; s = 1'b0; m = 1'b0; b = 1'b0; d = 1'b0;
    if (k >= 1 && k <= 34 * hp) begin
      c = 1'b0;
      b = 1'b1;
      if (k > hp && k <= 33 * hp) begin
        h = (k - hp - 1) / hp;
        s = (h % 2 == 0);
        m = fr[15 - h / 2];
      end else if (k > 33 * hp) begin
        m = fr[0];
      end
    end
    if (k == 34 * hp + 1) d = 1'b1;
    o = {c, s, m, b, d};
  endfunction

  // Slave: bit for rising edge n is held until the next rising edge; edges 9..16 carry rx MSB first.
  function automatic logic miso_bit(input int k, input int hp, input logic [7:0] rx,
                                    input logic [7:0] junk);
    int h, n;
    if (k > hp && k <= 33 * hp) begin
      h = (k - hp - 1) / hp;
      n = h / 2 + 1;
      if (n >= 9) return rx[16 - n];
      return junk[n - 1];
    end
    return junk[0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mk[i]   <= 0;
        mexp[i] <= 8'h00;
      end else begin
        if ((mk[i] == 0 || mk[i] == 34 * hp_of(i) + 1) && start) begin
          mk[i]    <= 1;
          mfr[i]   <= {rw, addr, (rw ? 8'h00 : wdata)};
          mrw[i]   <= rw;
          mrx[i]   <= nrx[i];
          mjunk[i] <= njunk;
        end else if (mk[i] == 0 || mk[i] == 34 * hp_of(i) + 1) begin
          mk[i] <= 0;
        end else begin
          mk[i] <= mk[i] + 1;
        end
        if (mk[i] == 34 * hp_of(i) && mrw[i]) mexp[i] <= mrx[i];
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) miso_w[i] <= miso_bit(mk[i], hp_of(i), mrx[i], mjunk[i]);
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    logic [4:0] o;
    if (run) begin
      for (int i = 0; i < 2; i++) begin
        exp_out(mk[i], hp_of(i), mfr[i], o);
        check($sformatf("cycle_dut%0d_k%0d", i, mk[i]),
              {19'd0, cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], done_w[i], rdata_w[i]},
              {19'd0, o, mexp[i]});
      end
    end
  end

  // Waveform measurements used by the literal checks.
  int          cyc = 0;
  int          low_cnt [2] = '{0, 0}, last_low [2] = '{0, 0};
  int          high_cnt [2] = '{0, 0}, last_gap [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0}, last_rise [2] = '{0, 0}, last_period [2] = '{0, 0};
  logic [15:0] cap [2], last_cap [2];
  logic        psclk [2] = '{1'b0, 1'b0}, pcs [2] = '{1'b1, 1'b1};

  always @(negedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      psclk[i] <= sclk_w[i];
      pcs[i]   <= cs_w[i];
      if (!cs_w[i]) low_cnt[i] <= low_cnt[i] + 1;
      else          high_cnt[i] <= high_cnt[i] + 1;
      if (cs_w[i] && !pcs[i]) begin
        last_low[i] <= low_cnt[i];
        last_cap[i] <= cap[i];
        high_cnt[i] <= 1;
      end
      if (!cs_w[i] && pcs[i]) begin
        last_gap[i] <= high_cnt[i];
        low_cnt[i]  <= 1;
        cap[i]      <= 16'h0000;
      end
      if (psclk[i] && !sclk_w[i]) cap[i] <= {cap[i][14:0], mosi_w[i]};
      if (sclk_w[i] && !psclk[i]) begin
        last_period[i] <= cyc - last_rise[i];
        last_rise[i]   <= cyc;
      end
      if (done_w[i]) done_cnt[i] <= done_cnt[i] + 1;
    end
  end

  // Call just after a negedge; leaves start high across exactly one posedge.
  task automatic pulse_start(input logic r, input logic [6:0] a, input logic [7:0] w,
                             input logic [7:0] rx0, input logic [7:0] rx1);
    #1;
    rw = r; addr = a; wdata = w;
    nrx[0] = rx0; nrx[1] = rx1; njunk = 8'($urandom);
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (done_w[i] === 1'b1) break;
    end
    check($sformatf("done_seen_dut%0d", i), {31'd0, done_w[i]}, 32'd1);
  endtask

  initial begin
    int d0, r;
    logic p;
    repeat (3) @(negedge clk);
    run = 1'b1;
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_state_dut%0d", i),
            {cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], done_w[i], rdata_w[i]}, 13'h1000);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write 02/A5
    d0 = done_cnt[0];
    pulse_start(1'b0, 7'h02, 8'hA5, 8'h00, 8'h00);
    wait_done(0, 400);
    #1;
    check("write_mosi", last_cap[0], 16'h02A5);
    check("write_cs_low", last_low[0], 136);
    check("write_rdata_kept", rdata_w[0], 8'h00);
    check("write_done_once", done_cnt[0] - d0, 1);

    // Read 01 returning 3C
    @(negedge clk);
    pulse_start(1'b1, 7'h01, 8'h77, 8'h3C, 8'h3C);
    wait_done(0, 400);
    check("read_rdata", rdata_w[0], 8'h3C);
    check("read_busy_low", {31'd0, busy_w[0]}, 0);
    #1;
    check("read_mosi", last_cap[0], 16'h8100);
    check("read_rdata_hp2", rdata_w[1], 8'h3C);

    // start mid-frame is ignored
    @(negedge clk);
    d0 = done_cnt[0];
    pulse_start(1'b0, 7'h11, 8'h5A, 8'h00, 8'h00);
    repeat (19) @(negedge clk);
    pulse_start(1'b1, 7'h7F, 8'hFF, 8'hEE, 8'hEE);
    wait_done(0, 400);
    repeat (40) @(negedge clk);
    #1;
    check("ignored_start_done_once", done_cnt[0] - d0, 1);
    check("ignored_start_frame", last_cap[0], 16'h115A);

    // Back-to-back: start in the done cycle
    @(negedge clk);
    pulse_start(1'b0, 7'h03, 8'hC3, 8'h00, 8'h00);
    wait_done(0, 400);
    pulse_start(1'b1, 7'h04, 8'h00, 8'h96, 8'h96);
    wait_done(0, 400);
    #1;
    check("b2b_gap", last_gap[0], 1);
    check("b2b_cs_low", last_low[0], 136);
    check("b2b_rdata", rdata_w[0], 8'h96);

    // Reset after the 5th rising sclk edge
    @(negedge clk);
    pulse_start(1'b1, 7'h05, 8'h00, 8'h12, 8'h12);
    r = 0;
    p = sclk_w[0];
    for (int n = 0; n < 200 && r < 5; n++) begin
      @(negedge clk);
      if (sclk_w[0] && !p) r++;
      p = sclk_w[0];
    end
    check("rise5_reached", r, 5);
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      check($sformatf("midframe_reset_dut%0d", i),
            {cs_w[i], sclk_w[i], mosi_w[i], busy_w[i], rdata_w[i]}, 12'h800);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    pulse_start(1'b1, 7'h06, 8'h00, 8'hFF, 8'hFF);
    wait_done(0, 400);
    check("post_reset_read", rdata_w[0], 8'hFF);
    check("post_reset_read_hp2", rdata_w[1], 8'hFF);

    // HALF_PERIOD=2 read of 81
    @(negedge clk);
    pulse_start(1'b1, 7'h07, 8'h00, 8'h81, 8'h81);
    wait_done(1, 200);
    #1;
    check("hp2_rdata", rdata_w[1], 8'h81);
    check("hp2_cs_low", last_low[1], 68);
    check("hp2_sclk_period", last_period[1], 4);
    wait_done(0, 400);

    // Randomized traffic, including starts while busy
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      pulse_start(1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 160)) @(negedge clk);
    end
    repeat (200) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
